// File: rtl/sort_pkg.sv
// Shared constants and state encoding for the sort result reader.
package sort_pkg;

  // Default width of one two's-complement element.
  localparam int ELEM_W = 3;

  // Number of elements in one sorter result set.
  localparam int NUM_ELEM = 4;

  // Reader FSM: waiting for a result, or streaming a captured set.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/sort_reader.sv
// Captures a four-element sorter result on the rising edge of done and
// streams it out one element per valid/ready transfer. It flags sets that
// are not non-decreasing (signed) and remembers any result it had to drop.
module sort_reader
  import sort_pkg::*;
#(
  parameter int N = ELEM_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         done,
  input  logic [N-1:0] s0,
  input  logic [N-1:0] s1,
  input  logic [N-1:0] s2,
  input  logic [N-1:0] s3,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         order_err,
  output logic         overrun
);

  state_t         state_q;
  state_t         state_d;
  logic           done_q;
  logic [1:0]     idx;
  logic [N-1:0]   data_buf [NUM_ELEM];
  logic [N-1:0]   data_q;
  logic signed [N-1:0] sv [NUM_ELEM];

  logic cap;
  logic xfer;
  logic load;
  logic adv;
  logic drop;
  logic order_bad;

  // A result is taken once per rising edge of done, so a held level captures once.
  assign cap = done & ~done_q;

  assign sv[0] = s0;
  assign sv[1] = s1;
  assign sv[2] = s2;
  assign sv[3] = s3;

  // Signed order check of the incoming set: any adjacent pair out of order.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    order_bad = 1'b0;
    for (int i = 0; i < NUM_ELEM - 1; i++) begin
      if (sv[i] > sv[i+1]) order_bad = 1'b1;
    end
  end

  // State register; reset discards any set in flight at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, output mux and the load/advance/drop decisions.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    adv       = 1'b0;
    drop      = 1'b0;
    xfer      = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = data_q;
    unique case (state_q)
      IDLE: begin
        if (cap) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_data  = data_buf[idx];
        out_last  = (idx == 2'd3);
        xfer      = out_ready;
        if (xfer && idx == 2'd3) begin
          // A new result arriving with the final transfer is chained with no bubble.
          if (cap) load = 1'b1;
          else     state_d = IDLE;
        end else begin
          adv  = xfer;
          drop = cap;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Buffer, index, edge detector and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q    <= 1'b0;
      idx       <= 2'd0;
      data_q    <= '0;
      order_err <= 1'b0;
      overrun   <= 1'b0;
      // NOTE: the element buffer is reset too, so out_data is defined from reset onward.
      for (int i = 0; i < NUM_ELEM; i++) data_buf[i] <= '0;
    end else begin
      done_q <= done;
      // Tracks the presented element so out_data holds it once the FSM goes idle.
      data_q <= out_data;
      if (load) begin
        data_buf[0] <= s0;
        data_buf[1] <= s1;
        data_buf[2] <= s2;
        data_buf[3] <= s3;
        idx         <= 2'd0;
        order_err   <= order_bad;
      end else if (adv) begin
        idx <= idx + 2'd1;
      end
      if (drop) overrun <= 1'b1;
    end
  end

  assign busy = (state_q == SEND);

endmodule

// File: tb/tb_sort_reader.sv
// Directed bench for sort_reader: streaming, backpressure, order flag,
// overrun, back-to-back chaining and reset behaviour.
module tb_sort_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       done;
  logic [2:0] s0, s1, s2, s3;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_data;
  logic       out_last;
  logic       busy;
  logic       order_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_set [4];
  int         ntx;

  sort_reader #(.N(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .done      (done),
    .s0        (s0),
    .s1        (s1),
    .s2        (s2),
    .s3        (s3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .order_err (order_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: run did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // Advance one clock; sampling happens 1 ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_s(input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] c, input logic [2:0] d);
    s0 = a; s1 = b; s2 = c; s3 = d;
    exp_set[0] = a; exp_set[1] = b; exp_set[2] = c; exp_set[3] = d;
  endtask

  // Produce a fresh done rising edge; the capture happens at the second edge.
  task automatic capture();
    done = 1'b0;
    cyc();
    done = 1'b1;
    cyc();
  endtask

  // Drive a ready pattern for ncyc cycles and check each presented element.
  task automatic stream(input string tag, input int start, input logic [15:0] rdy, input int ncyc);
    ntx = start;
    for (int k = 0; k < ncyc; k++) begin
      out_ready = rdy[k];
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_data"}, out_data, exp_set[ntx]);
      check({tag, "_last"}, out_last, (ntx == 3) ? 1 : 0);
      if (rdy[k]) ntx++;
      cyc();
    end
  endtask

  initial begin
    rst = 1'b1; done = 1'b0; out_ready = 1'b0;
    s0 = '0; s1 = '0; s2 = '0; s3 = '0;
    cyc();
    cyc();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_order", order_err, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    cyc();

    // Basic stream of {-2,-1,2,3} with ready always high.
    set_s(3'd6, 3'd7, 3'd2, 3'd3);
    out_ready = 1'b1;
    capture();
    check("t1_busy", busy, 1);
    check("t1_order", order_err, 0);
    stream("t1", 0, 16'h000f, 4);
    check("t1_ntx", ntx, 4);
    check("t1_busy_end", busy, 0);
    check("t1_valid_end", out_valid, 0);
    check("t1_last_end", out_last, 0);
    check("t1_hold", out_data, 3);
    cyc();
    check("t1_no_recap", busy, 0);

    // Backpressure pattern 1,0,0,1,1,0,1.
    capture();
    stream("t2", 0, 16'b1011001, 7);
    check("t2_ntx", ntx, 4);
    check("t2_busy_end", busy, 0);

    // Out-of-order set, then an ordered set.
    set_s(3'd0, 3'd3, 3'd1, 3'd2);
    capture();
    check("t3_order_bad", order_err, 1);
    stream("t3a", 0, 16'h000f, 4);
    set_s(3'd0, 3'd1, 3'd2, 3'd3);
    capture();
    check("t3_order_ok", order_err, 0);
    stream("t3b", 0, 16'h000f, 4);

    // Capture coinciding with the final transfer chains without a bubble.
    set_s(3'd5, 3'd7, 3'd0, 3'd1);
    capture();
    done = 1'b0;
    stream("t4a", 0, 16'h0007, 3);
    check("t4_at_last", out_last, 1);
    check("t4_last_data", out_data, 1);
    set_s(3'd4, 3'd6, 3'd1, 3'd2);
    done = 1'b1;
    out_ready = 1'b1;
    cyc();
    check("t4_chain_busy", busy, 1);
    check("t4_chain_overrun", overrun, 0);
    stream("t4b", 0, 16'h000f, 4);
    check("t4_chain_busy_end", busy, 0);
    check("t4_overrun_end", overrun, 0);

    // Capture while idx=1 and ready low is dropped and flags overrun.
    set_s(3'd5, 3'd7, 3'd0, 3'd1);
    capture();
    done = 1'b0;
    stream("t5a", 0, 16'h0001, 1);
    out_ready = 1'b0;
    s0 = 3'd2; s1 = 3'd2; s2 = 3'd3; s3 = 3'd3;
    done = 1'b1;
    cyc();
    check("t5_overrun", overrun, 1);
    check("t5_hold_data", out_data, 7);
    stream("t5b", 1, 16'h0007, 3);
    check("t5_ntx", ntx, 4);
    check("t5_busy_end", busy, 0);
    check("t5_overrun_sticky", overrun, 1);

    // Reset mid-stream with order_err and overrun set, done held over release.
    set_s(3'd0, 3'd3, 3'd1, 3'd2);
    capture();
    check("t6_order", order_err, 1);
    stream("t6a", 0, 16'h0003, 2);
    set_s(3'd5, 3'd7, 3'd0, 3'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_order", order_err, 0);
    check("t6_rst_overrun", overrun, 0);
    check("t6_rst_last", out_last, 0);
    check("t6_rst_data", out_data, 0);
    cyc();
    rst = 1'b0;
    check("t6_idle", busy, 0);
    cyc();
    check("t6_recap_busy", busy, 1);
    stream("t6b", 0, 16'h000f, 4);
    check("t6_busy_end", busy, 0);
    check("t6_order_end", order_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
